// File: rtl/univ_shift_reg.sv
// Multi-lane universal shift register: hold, shift right/left, rotate and parallel load.
// Latency: one cycle from a load/shift edge to q; sout_r/sout_l are combinational taps of q.
// Backpressure: none; en=0 freezes all state and suppresses frame_done.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       rot,
    input  logic [LANES-1:0]           sin_r,
    input  logic [LANES-1:0]           sin_l,
    input  logic [LANES*WIDTH-1:0]     pdata,
    output logic [LANES*WIDTH-1:0]     q,
    output logic [LANES-1:0]           sout_r,
    output logic [LANES-1:0]           sout_l,
    output logic [$clog2(WIDTH)-1:0]   cnt,
    output logic                       frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [LANES*WIDTH-1:0] q_nxt;
    logic                   shift_op;

    assign shift_op = (mode == MODE_RIGHT) || (mode == MODE_LEFT);

    // Each lane only ever reads its own slice, so nothing leaks across lanes.
    always_comb begin
        q_nxt = q;
        for (int k = 0; k < LANES; k++) begin
            case (mode)
                MODE_RIGHT: q_nxt[k*WIDTH +: WIDTH] =
                    {(rot ? q[k*WIDTH] : sin_r[k]), q[k*WIDTH+1 +: WIDTH-1]};
                MODE_LEFT:  q_nxt[k*WIDTH +: WIDTH] =
                    {q[k*WIDTH +: WIDTH-1], (rot ? q[k*WIDTH+WIDTH-1] : sin_l[k])};
                MODE_LOAD:  q_nxt[k*WIDTH +: WIDTH] = pdata[k*WIDTH +: WIDTH];
                default:    q_nxt[k*WIDTH +: WIDTH] = q[k*WIDTH +: WIDTH];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (en) begin
            q          <= q_nxt;
            frame_done <= 1'b0;
            if (mode == MODE_LOAD) begin
                cnt <= '0;
            end else if (shift_op) begin
                if (cnt == CNT_LAST) begin
                    cnt        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_taps
        assign sout_r[k] = q[k*WIDTH];
        assign sout_l[k] = q[k*WIDTH+WIDTH-1];
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: vector table, directed corner sequences, randomized run vs. a lane model.
module tb_univ_shift_reg;

    localparam int W = 8;
    localparam int L = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic           rot = 1'b0;
    logic [L-1:0]   sin_r = '0;
    logic [L-1:0]   sin_l = '0;
    logic [L*W-1:0] pdata = '0;
    logic [L*W-1:0] q;
    logic [L-1:0]   sout_r, sout_l;
    logic [2:0]     cnt;
    logic           frame_done;

    logic           en4 = 1'b0;
    logic [1:0]     mode4 = 2'b00;
    logic           rot4 = 1'b0;
    logic [0:0]     sin_r4 = '0;
    logic [0:0]     sin_l4 = '0;
    logic [3:0]     pdata4 = '0;
    logic [3:0]     q4;
    logic [0:0]     sout_r4, sout_l4;
    logic [1:0]     cnt4;
    logic           fd4;

    univ_shift_reg #(.WIDTH(W), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .pdata(pdata), .q(q),
        .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .frame_done(frame_done)
    );

    univ_shift_reg #(.WIDTH(4), .LANES(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .rot(rot4),
        .sin_r(sin_r4), .sin_l(sin_l4), .pdata(pdata4), .q(q4),
        .sout_r(sout_r4), .sout_l(sout_l4), .cnt(cnt4), .frame_done(fd4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: each lane is an integer value, counter is total shifts since load.
    int mq[L];
    int mshifts;
    bit mfd;

    typedef struct {
        logic        e;
        logic [1:0]  m;
        logic        r;
        logic [1:0]  sr;
        logic [1:0]  sl;
        logic [15:0] pd;
        logic [15:0] xq;
        logic [2:0]  xc;
        logic        xf;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < L; k++) mq[k] = 0;
        mshifts = 0;
        mfd = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic [1:0] m, input logic r,
                              input logic [1:0] sr, input logic [1:0] sl, input logic [15:0] pd);
        int b;
        mfd = 1'b0;
        if (!e) return;
        if (m == 2'd3) begin
            for (int k = 0; k < L; k++) mq[k] = (int'(pd) >> (8 * k)) & 255;
            mshifts = 0;
        end else if (m != 2'd0) begin
            for (int k = 0; k < L; k++) begin
                if (m == 2'd1) begin
                    b = r ? (mq[k] % 2) : int'(sr[k]);
                    mq[k] = (mq[k] / 2) + b * 128;
                end else begin
                    b = r ? (mq[k] / 128) : int'(sl[k]);
                    mq[k] = ((mq[k] * 2) % 256) + b;
                end
            end
            mshifts++;
            mfd = (mshifts % W) == 0;
        end
    endtask

    function automatic logic [15:0] model_q();
        return 16'(mq[1] * 256 + mq[0]);
    endfunction

    // One clock: drive, model the edge, then compare at the falling edge.
    task automatic cyc(input string nm, input logic e, input logic [1:0] m, input logic r,
                       input logic [1:0] sr, input logic [1:0] sl, input logic [15:0] pd);
        en = e; mode = m; rot = r; sin_r = sr; sin_l = sl; pdata = pd;
        @(posedge clk);
        model_step(e, m, r, sr, sl, pd);
        @(negedge clk);
        chk({nm, "_q"}, q, model_q());
        chk({nm, "_cnt"}, cnt, mshifts % W);
        chk({nm, "_fd"}, frame_done, mfd);
        chk({nm, "_sout_r"}, sout_r, {mq[1][0], mq[0][0]});
        chk({nm, "_sout_l"}, sout_l, {mq[1][7], mq[0][7]});
    endtask

    initial begin
        logic [7:0] a5;
        int pulses;

        tbl[0] = '{1'b1, 2'd3, 1'b0, 2'b00, 2'b00, 16'h3CA5, 16'h3CA5, 3'd0, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 1'b0, 2'b01, 2'b00, 16'h0000, 16'h1ED2, 3'd1, 1'b0};
        tbl[2] = '{1'b1, 2'd2, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h3CA5, 3'd2, 1'b0};
        tbl[3] = '{1'b0, 2'd1, 1'b0, 2'b11, 2'b11, 16'hFFFF, 16'h3CA5, 3'd2, 1'b0};
        tbl[4] = '{1'b1, 2'd0, 1'b0, 2'b11, 2'b11, 16'hFFFF, 16'h3CA5, 3'd2, 1'b0};
        tbl[5] = '{1'b1, 2'd2, 1'b0, 2'b00, 2'b10, 16'h0000, 16'h794A, 3'd3, 1'b0};
        tbl[6] = '{1'b1, 2'd1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'hBC25, 3'd4, 1'b0};
        tbl[7] = '{1'b1, 2'd3, 1'b0, 2'b00, 2'b00, 16'hFF00, 16'hFF00, 3'd0, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_q", q, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_q4", q4, 0);
        rst_n = 1'b1;

        // Serial latency on the 4-bit instance: one '1' bit travels to sout_r.
        en4 = 1'b1; mode4 = 2'd1;
        for (int i = 1; i <= 8; i++) begin
            sin_r4 = (i == 1) ? 1'b1 : 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("lat_sout_r", sout_r4, (i == 4) ? 1 : 0);
            chk("lat_fd", fd4, (i % 4 == 0) ? 1 : 0);
        end
        en4 = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cyc("vec", tbl[i].e, tbl[i].m, tbl[i].r, tbl[i].sr, tbl[i].sl, tbl[i].pd);
            chk("vec_q_const", q, tbl[i].xq);
            chk("vec_cnt_const", cnt, tbl[i].xc);
            chk("vec_fd_const", frame_done, tbl[i].xf);
        end

        // Serialise 0xA5 out of lane 0, LSB first.
        a5 = 8'hA5;
        cyc("ser_load", 1'b1, 2'd3, 1'b0, 2'b00, 2'b00, 16'h00A5);
        for (int i = 0; i < 8; i++) begin
            chk("ser_bit", sout_r[0], a5[i]);
            chk("ser_fd_low", frame_done, 0);
            cyc("ser", 1'b1, 2'd1, 1'b0, 2'b00, 2'b00, 16'h0000);
        end
        chk("ser_fd_high", frame_done, 1);
        chk("ser_cnt_wrap", cnt, 0);
        cyc("ser_after", 1'b1, 2'd0, 1'b0, 2'b00, 2'b00, 16'h0000);
        chk("ser_fd_once", frame_done, 0);

        // Rotate left: 0x81 -> 0x0C after 3, back to 0x81 after 8.
        cyc("rot_load", 1'b1, 2'd3, 1'b0, 2'b00, 2'b00, 16'h1881);
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc("rot", 1'b1, 2'd2, 1'b1, 2'b11, 2'b11, 16'h0000);
            pulses += int'(frame_done);
            if (i == 3) chk("rot3_q", q, 16'hC00C);
        end
        chk("rot8_q", q, 16'h1881);
        cyc("rot_after", 1'b1, 2'd0, 1'b0, 2'b00, 2'b00, 16'h0000);
        pulses += int'(frame_done);
        chk("rot_pulses", pulses, 1);

        // Lane independence: lane1 drains to 0, lane0 fills with ones.
        cyc("lane_load", 1'b1, 2'd3, 1'b0, 2'b00, 2'b00, 16'hFF00);
        for (int i = 1; i <= 8; i++) begin
            cyc("lane", 1'b1, 2'd2, 1'b0, 2'b00, 2'b01, 16'h0000);
            chk("lane0_fill", q[7:0], (1 << i) - 1);
            chk("lane1_drain", q[15:8], (255 << i) & 255);
        end
        chk("lane_final", q, 16'h00FF);

        // Enable gating mid-frame.
        cyc("hold_load", 1'b1, 2'd3, 1'b0, 2'b00, 2'b00, 16'h5A3C);
        for (int i = 0; i < 5; i++) cyc("hold_pre", 1'b1, 2'd1, 1'b0, 2'b10, 2'b00, 16'h0000);
        chk("hold_cnt5", cnt, 5);
        for (int i = 0; i < 3; i++) begin
            cyc("hold_off", 1'b0, 2'd1, 1'b0, 2'b11, 2'b11, 16'h0000);
            chk("hold_cnt", cnt, 5);
            chk("hold_fd", frame_done, 0);
        end
        for (int i = 1; i <= 3; i++) begin
            cyc("hold_on", 1'b1, 2'd1, 1'b0, 2'b00, 2'b00, 16'h0000);
            chk("hold_resume_fd", frame_done, (i == 3) ? 1 : 0);
        end

        // Asynchronous reset while a frame_done pulse is showing.
        cyc("ar_load", 1'b1, 2'd3, 1'b0, 2'b00, 2'b00, 16'h1234);
        for (int i = 0; i < 8; i++) cyc("ar", 1'b1, 2'd1, 1'b1, 2'b00, 2'b00, 16'h0000);
        chk("ar_pre_fd", frame_done, 1);
        chk("ar_pre_q", q, 16'h1234);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_q", q, 0);
        chk("ar_cnt", cnt, 0);
        chk("ar_fd", frame_done, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc("ar_post", 1'b1, 2'd0, 1'b0, 2'b00, 2'b00, 16'h0000);

        // Randomized run against the lane model.
        for (int i = 0; i < 400; i++) begin
            cyc("rnd", ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
                2'($urandom), 2'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
